// File: rtl/snow64_count_leading_zeros_16_pkg.sv
// rtl/snow64_count_leading_zeros_16_pkg.sv - shared widths and types for the 16-bit leading-zero counter
package PkgSnow64CountLeadingZeros;

    // Widths mirror the MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_IN/_OUT defines.
    localparam int MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_IN  = 15;
    localparam int MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_OUT = 4;
    localparam int WIDTH__SNOW64_COUNT_LEADING_ZEROS_16_IN    = MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_IN + 1;
    localparam int WIDTH__SNOW64_COUNT_LEADING_ZEROS_16_OUT   = MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_OUT + 1;

    // Byte-level counter used twice by the 16-bit top.
    localparam int MSB_POS__SNOW64_COUNT_LEADING_ZEROS_8_IN  = 7;
    localparam int MSB_POS__SNOW64_COUNT_LEADING_ZEROS_8_OUT = 3;

    typedef logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_IN:0]  clz16_in_t;
    typedef logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_OUT:0] clz16_out_t;
    typedef logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_8_IN:0]   clz8_in_t;
    typedef logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_8_OUT:0]  clz8_out_t;

    // Value a byte counter reports when its whole byte is zero.
    localparam clz8_out_t CLZ8_ALL_ZERO = 4'd8;

endpackage

// File: rtl/snow64_count_leading_zeros_8.sv
// rtl/snow64_count_leading_zeros_8.sv - combinational 8-bit leading-zero count, result 0..8
module snow64_count_leading_zeros_8
    import PkgSnow64CountLeadingZeros::*;
(
    input  logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_8_IN:0]  in,
    output logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_8_OUT:0] out
);

    // Scan LSB to MSB so the highest set bit is the last one to assign the count.
    always_comb begin
        out = CLZ8_ALL_ZERO;
        for (int i = 0; i <= MSB_POS__SNOW64_COUNT_LEADING_ZEROS_8_IN; i++) begin
            if (in[i]) begin
                out = clz8_out_t'(MSB_POS__SNOW64_COUNT_LEADING_ZEROS_8_IN - i);
            end
        end
    end

endmodule

// File: rtl/snow64_count_leading_zeros_16.sv
// rtl/snow64_count_leading_zeros_16.sv - 16-bit leading-zero count with combinational and registered outputs
module snow64_count_leading_zeros_16
    import PkgSnow64CountLeadingZeros::*;
(
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_IN:0]  in,
    input  logic                                                in_valid,
    output logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_OUT:0] out,
    output logic [MSB_POS__SNOW64_COUNT_LEADING_ZEROS_16_OUT:0] out_q,
    output logic                                                out_valid
);

    clz8_out_t  clz_hi;
    clz8_out_t  clz_lo;
    clz16_out_t out_d;
    logic       out_valid_d;

    snow64_count_leading_zeros_8 u_clz_hi (
        .in  (in[15:8]),
        .out (clz_hi)
    );

    snow64_count_leading_zeros_8 u_clz_lo (
        .in  (in[7:0]),
        .out (clz_lo)
    );

    // High byte decides unless it is all zero; then the low byte adds on top of 8.
    always_comb begin
        out = {1'b0, clz_hi};
        if (clz_hi == CLZ8_ALL_ZERO) begin
            out = {1'b0, clz_lo} + 5'd8;
        end
    end

    // Next-state for the register stage: capture on in_valid, otherwise hold the count.
    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = out;
        end
    end

    // Single pipeline register; reset clears any pending result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_snow64_count_leading_zeros_16.sv
// tb/tb_snow64_count_leading_zeros_16.sv - self-checking bench for the 16-bit leading-zero counter
module tb_snow64_count_leading_zeros_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        in_valid;
    logic [4:0]  out;
    logic [4:0]  out_q;
    logic        out_valid;

    int n_checks;
    int n_passed;

    snow64_count_leading_zeros_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leading zeros = 16 - bit length of the value (bit length of 0 is 0).
    function automatic int ref_clz(input logic [15:0] v);
        int x;
        x = int'(v);
        return 16 - $clog2(x + 1);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Present a word between edges and check the combinational count.
    task automatic comb_check(input string tag, input logic [15:0] v, input int exp);
        @(negedge clk);
        in = v;
        #1;
        check(tag, int'(out), exp);
    endtask

    logic [15:0] dir_vals [6] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0001, 16'h00F0, 16'h0100};
    int          dir_exp  [6] = '{16, 0, 0, 15, 8, 7};

    initial begin
        int          exp_q;
        logic [15:0] v;
        int          k;
        logic        iv;

        n_checks = 0;
        n_passed = 0;
        rst_n    = 1'b0;
        in       = 16'h0000;
        in_valid = 1'b0;
        #2;
        check("reset_out_q", int'(out_q), 0);
        check("reset_out_valid", int'(out_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner values
        for (int i = 0; i < 6; i++) begin
            comb_check("directed", dir_vals[i], dir_exp[i]);
            check("directed_model", ref_clz(dir_vals[i]), dir_exp[i]);
        end
        comb_check("lower_bits_0A5F", 16'h0A5F, 4);

        // Walking one
        for (int j = 15; j >= 0; j--) begin
            v = 16'h0001 << j;
            comb_check("walking_one", v, 15 - j);
        end

        // Random bits below a chosen leading one
        for (int j = 0; j < 40; j++) begin
            k = $urandom_range(15, 0);
            v = (16'h0001 << k) | (16'($urandom) & ((16'h0001 << k) - 16'h0001));
            comb_check("random_below_lead", v, 15 - k);
        end

        // Random words with random in_valid: comb and registered paths vs model
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q = int'(out_q);
        check("valid_idle", int'(out_valid), 0);
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            v  = 16'($urandom);
            if (($urandom & 3) == 0) v = v >> $urandom_range(15, 0);
            iv = 1'($urandom);
            in       = v;
            in_valid = iv;
            #1;
            check("rand_comb", int'(out), ref_clz(v));
            if (iv) exp_q = ref_clz(v);
            @(posedge clk);
            #1;
            check("rand_out_valid", int'(out_valid), int'(iv));
            check("rand_out_q", int'(out_q), exp_q);
        end

        // Back-to-back pipeline: 8000, 0400, 0000 -> 0, 5, 16
        @(negedge clk);
        in = 16'h8000; in_valid = 1'b1;
        @(posedge clk); #1;
        check("pipe0_q", int'(out_q), 0);
        check("pipe0_v", int'(out_valid), 1);
        @(negedge clk);
        in = 16'h0400;
        @(posedge clk); #1;
        check("pipe1_q", int'(out_q), 5);
        check("pipe1_v", int'(out_valid), 1);
        @(negedge clk);
        in = 16'h0000;
        @(posedge clk); #1;
        check("pipe2_q", int'(out_q), 16);
        check("pipe2_v", int'(out_valid), 1);
        @(negedge clk);
        in = 16'h1234; in_valid = 1'b0;
        @(posedge clk); #1;
        check("pipe_idle_q", int'(out_q), 16);
        check("pipe_idle_v", int'(out_valid), 0);

        // Asynchronous reset while a result is valid
        @(negedge clk);
        in = 16'h00FF; in_valid = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_v", int'(out_valid), 1);
        check("pre_reset_q", int'(out_q), 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_q", int'(out_q), 0);
        check("async_reset_v", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in = 16'h0002; in_valid = 1'b1;
        @(posedge clk); #1;
        check("post_reset_q", int'(out_q), 14);
        check("post_reset_v", int'(out_valid), 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle_v", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
